fifo_rd_stream: RTL

Read-domain consumer for the async dual-clock FIFO. It drives the FIFO read request (r_en) and captures memory read data into a 2-entry output buffer. That data is presented downstream as a valid/ready stream. It also derives a registered read-side occupancy level and an almost_empty flag from the synchronized gray write pointer and the local gray read pointer.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_gray2bin.sv | 13 +
 rtl/fifo_rd_stream.sv | 110 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async dual-clock FIFO: default sizes, output
// buffer occupancy encoding and gray/binary pointer conversions.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  // Conversions run at a fixed wide width; callers zero-extend and truncate.
  localparam int unsigned CONV_W = 32;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_cnt_e;

  // XOR-prefix from the MSB; zero-extended upper bits leave the result unchanged.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin[CONV_W-1] = gray[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational gray-to-binary converter for one FIFO pointer.
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_WIDTH + 1
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(gray2bin(CONV_W'(i_gray)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO: 2-entry skid buffer feeding a
// valid/ready stream, plus registered occupancy level and almost_empty.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  almost_empty
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  buf_cnt_e              r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_head, w_head_nxt;
  logic [DATA_WIDTH-1:0] r_skid, w_skid_nxt;
  logic                  w_pop, w_take;
  logic [PTR_W-1:0]      w_wbin, w_rbin, w_level_nxt;

  assign w_pop   = r_en & ~empty;
  assign m_valid = (r_cnt != BUF_EMPTY);
  assign w_take  = m_valid & m_ready;
  assign m_data  = r_head;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    case (r_cnt)
      BUF_EMPTY: begin
        if (w_pop) begin
          w_head_nxt = r_data;
          w_cnt_nxt  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (w_pop && !w_take) begin
          w_skid_nxt = r_data;
          w_cnt_nxt  = BUF_TWO;
        end else if (!w_pop && w_take) begin
          w_cnt_nxt  = BUF_EMPTY;
        end else if (w_pop && w_take) begin
          w_head_nxt = r_data;
        end
      end
      BUF_TWO: begin
        // r_en is low here, so only a take can move the buffer.
        if (w_take) begin
          w_head_nxt = r_skid;
          w_cnt_nxt  = BUF_ONE;
        end
      end
      default: w_cnt_nxt = BUF_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the two data entries are reset too, so m_data reads zero out of reset.
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_cnt  <= BUF_EMPTY;
      r_head <= '0;
      r_skid <= '0;
      r_en   <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_head <= w_head_nxt;
      r_skid <= w_skid_nxt;
      // Registered request: equals (cnt < 2) with no path from empty or m_ready.
      r_en   <= (w_cnt_nxt != BUF_TWO);
    end
  end

  fifo_gray2bin #(.WIDTH(PTR_W)) u_wptr_bin (
    .i_gray (rq2_wptr),
    .o_bin  (w_wbin)
  );

  fifo_gray2bin #(.WIDTH(PTR_W)) u_rptr_bin (
    .i_gray (rptr_gray),
    .o_bin  (w_rbin)
  );

  // Modulo subtract absorbs the pointer MSB wrap; a full FIFO reads 2**ADDR_WIDTH.
  assign w_level_nxt = w_wbin - w_rbin;

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      r_level      <= '0;
      almost_empty <= 1'b1;
    end else begin
      r_level      <= w_level_nxt;
      almost_empty <= (w_level_nxt <= PTR_W'(AE_THRESH));
    end
  end

endmodule
